// File: rtl/countdown_timer_mmss.sv
// Minutes:seconds countdown timer.
// The count is kept as four BCD digits (index 0 = seconds ones .. 3 = minutes
// tens) so the display stage can use them directly; binary-to-BCD conversion
// only happens on load. A four-state FSM (IDLE/RUN/PAUSED/ALARM) gates the
// 1 Hz decrement and times the alarm for ALARM_TICKS seconds.
module countdown_timer_mmss #(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    localparam logic [6:0] MAX_MIN_L     = 7'(MAX_MIN);
    localparam logic [3:0] ALARM_TICKS_L = 4'(ALARM_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_ALARM
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] digit_reg  [4];
    logic [3:0] digit_next [4];
    logic [3:0] dec_digit  [4];
    logic [3:0] load_digit [4];
    logic [4:0] borrow;
    logic [3:0] alarm_cnt_reg, alarm_cnt_next;
    logic       done_reg, done_next;
    logic       count_zero;
    logic       dec_zero;
    logic [6:0] min_clamped;
    logic [5:0] sec_clamped;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;

    // Split a value below 100 into {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 9; i >= 1; i--) begin
            if (tens == 4'd0 && v >= 7'(i * 10)) begin
                tens = 4'(i);
                rem  = v - 7'(i * 10);
            end
        end
        return {tens, 4'(rem)};
    endfunction

    // Clamp load values and convert them to BCD digits.
    assign min_clamped   = (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
    assign sec_clamped   = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign min_bcd       = to_bcd(min_clamped);
    assign sec_bcd       = to_bcd({1'b0, sec_clamped});
    assign load_digit[0] = sec_bcd[3:0];
    assign load_digit[1] = sec_bcd[7:4];
    assign load_digit[2] = min_bcd[3:0];
    assign load_digit[3] = min_bcd[7:4];

    // Borrow ripple: a digit decrements when everything below it is zero.
    // Seconds tens wraps 0 -> 5, every other digit wraps 0 -> 9.
    // A borrow out of the top digit means the whole count is 00:00.
    assign borrow[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;
            assign borrow[gi+1]  = borrow[gi] && (digit_reg[gi] == 4'd0);
            assign dec_digit[gi] = !borrow[gi]            ? digit_reg[gi] :
                                   (digit_reg[gi] == 4'd0) ? WRAP          :
                                                             digit_reg[gi] - 4'd1;
        end
    endgenerate

    assign count_zero = borrow[4];
    assign dec_zero   = (dec_digit[0] == 4'd0) && (dec_digit[1] == 4'd0) &&
                        (dec_digit[2] == 4'd0) && (dec_digit[3] == 4'd0);

    // Next-state, next-count and alarm-counter logic; load beats pause beats start.
    always_comb begin
        state_next     = state_reg;
        digit_next     = digit_reg;
        alarm_cnt_next = alarm_cnt_reg;

        if (load && state_reg != S_RUN) begin
            digit_next     = load_digit;
            state_next     = S_IDLE;
            alarm_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !pause && !count_zero) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    // A tick still lands when pause arrives in the same cycle,
                    // and reaching zero sends us to ALARM rather than PAUSED.
                    if (tick_1hz && !count_zero) begin
                        digit_next = dec_digit;
                        if (dec_zero) begin
                            state_next     = S_ALARM;
                            alarm_cnt_next = ALARM_TICKS_L;
                        end else if (pause) begin
                            state_next = S_PAUSED;
                        end
                    end else if (pause) begin
                        state_next = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (start && !pause) begin
                        state_next = S_RUN;
                    end
                end
                S_ALARM: begin
                    if (start || pause) begin
                        state_next     = S_IDLE;
                        alarm_cnt_next = 4'd0;
                    end else if (tick_1hz) begin
                        if (alarm_cnt_reg <= 4'd1) begin
                            state_next     = S_IDLE;
                            alarm_cnt_next = 4'd0;
                        end else begin
                            alarm_cnt_next = alarm_cnt_reg - 4'd1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        done_next = (state_next == S_ALARM) && (state_reg != S_ALARM);
    end

    // State, count, alarm counter and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            digit_reg     <= '{default: 4'd0};
            alarm_cnt_reg <= 4'd0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_reg     <= digit_next;
            alarm_cnt_reg <= alarm_cnt_next;
            done_reg      <= done_next;
        end
    end

    assign sec_ones = digit_reg[0];
    assign sec_tens = digit_reg[1];
    assign min_ones = digit_reg[2];
    assign min_tens = digit_reg[3];
    assign running  = (state_reg == S_RUN);
    assign alarm    = (state_reg == S_ALARM);
    assign done     = done_reg;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Testbench for countdown_timer_mmss: directed vector table, an asynchronous
// reset check, then random stimulus against a seconds-based reference model.
module tb_countdown_timer_mmss;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       load;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       pause;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm, done;

    int checks = 0;
    int errors = 0;

    countdown_timer_mmss #(.MAX_MIN(99), .ALARM_TICKS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .alarm    (alarm),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model: the count is total seconds; state 0 idle, 1 run, 2 paused, 3 alarm.
    int m_secs, m_state, m_acnt;
    bit m_done;

    function automatic void model_reset();
        m_secs = 0; m_state = 0; m_acnt = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit ld, int lm, int ls, bit st, bit ps, bit tk);
        m_done = 0;
        if (ld && m_state != 1) begin
            m_secs  = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
            m_state = 0;
            m_acnt  = 0;
        end else begin
            case (m_state)
                0: if (st && !ps && m_secs > 0) m_state = 1;
                1: begin
                    if (tk && m_secs > 0) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_state = 3; m_acnt = 5; m_done = 1;
                        end else if (ps) m_state = 2;
                    end else if (ps) m_state = 2;
                end
                2: if (st && !ps) m_state = 1;
                default: begin
                    if (st || ps) m_state = 0;
                    else if (tk) begin
                        m_acnt = m_acnt - 1;
                        if (m_acnt == 0) m_state = 0;
                    end
                end
            endcase
        end
    endfunction

    function automatic int model_bcd();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return (mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10);
    endfunction

    function automatic int dut_bcd();
        return int'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    function automatic int dut_flags();
        return int'({running, alarm, done});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, model on posedge, leave #1 after the edge.
    task automatic step(input bit ld, input int lm, input int ls, input bit st, input bit ps, input bit tk);
        @(negedge clk);
        load = ld; load_min = 7'(lm); load_sec = 6'(ls);
        start = st; pause = ps; tick_1hz = tk;
        @(posedge clk);
        model_step(ld, lm, ls, st, ps, tk);
        #1;
        load = 0; start = 0; pause = 0; tick_1hz = 0;
    endtask

    typedef struct {
        bit          ld;
        int          lm;
        int          ls;
        bit          st;
        bit          ps;
        bit          tk;
        logic [15:0] exp_bcd;
        bit          exp_run;
        bit          exp_alm;
        bit          exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit ld, int lm, int ls, bit st, bit ps, bit tk,
                                logic [15:0] b, bit r, bit a, bit d);
        vec_t v;
        v.ld = ld; v.lm = lm; v.ls = ls; v.st = st; v.ps = ps; v.tk = tk;
        v.exp_bcd = b; v.exp_run = r; v.exp_alm = a; v.exp_done = d;
        tbl.push_back(v);
    endfunction

    initial begin
        // ld lm ls st ps tk   bcd      run alm done
        add(1, 1,  5, 0, 0, 0, 16'h0105, 0, 0, 0);
        add(1, 0,  3, 0, 0, 0, 16'h0003, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0003, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0002, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0001, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 1, 1);
        add(0, 0,  0, 0, 0, 0, 16'h0000, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 0, 0);
        add(1, 1,  0, 0, 0, 0, 16'h0100, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0100, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0059, 1, 0, 0);
        add(1, 5,  0, 0, 0, 0, 16'h0059, 1, 0, 0);
        add(1, 5,  0, 0, 0, 1, 16'h0058, 1, 0, 0);
        add(0, 0,  0, 0, 1, 0, 16'h0058, 0, 0, 0);
        add(1, 10, 0, 0, 0, 0, 16'h1000, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h1000, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0959, 1, 0, 0);
        add(0, 0,  0, 0, 1, 0, 16'h0959, 0, 0, 0);
        add(1, 0, 10, 0, 0, 0, 16'h0010, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0010, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0009, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0008, 1, 0, 0);
        add(0, 0,  0, 0, 1, 1, 16'h0007, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 16'h0007, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0007, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0006, 1, 0, 0);
        add(0, 0,  0, 0, 1, 0, 16'h0006, 0, 0, 0);
        add(1, 120, 63, 0, 0, 0, 16'h9959, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0,  1, 0, 0, 0, 16'h0001, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0001, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 1, 1);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 1, 0);
        add(0, 0,  0, 0, 1, 0, 16'h0000, 0, 0, 0);
        add(1, 0,  2, 0, 0, 0, 16'h0002, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0002, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0001, 1, 0, 0);
        add(0, 0,  0, 0, 0, 1, 16'h0000, 0, 1, 1);
        add(1, 2, 30, 1, 0, 0, 16'h0230, 0, 0, 0);
        add(1, 0,  1, 0, 0, 0, 16'h0001, 0, 0, 0);
        add(0, 0,  0, 1, 0, 0, 16'h0001, 1, 0, 0);
        add(0, 0,  0, 0, 1, 1, 16'h0000, 0, 1, 1);
        add(0, 0,  0, 1, 0, 0, 16'h0000, 0, 0, 0);

        // Reset state
        reset = 1; load = 0; load_min = 0; load_sec = 0;
        start = 0; pause = 0; tick_1hz = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd", dut_bcd(), 0);
        chk("reset_flags", dut_flags(), 0);
        $display("reset: bcd=%h run=%b alarm=%b done=%b", dut_bcd(), running, alarm, done);
        @(negedge clk);
        reset = 0;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ld, tbl[i].lm, tbl[i].ls, tbl[i].st, tbl[i].ps, tbl[i].tk);
            chk($sformatf("vec%0d_bcd", i), dut_bcd(), int'(tbl[i].exp_bcd));
            chk($sformatf("vec%0d_flags", i), dut_flags(),
                int'({tbl[i].exp_run, tbl[i].exp_alm, tbl[i].exp_done}));
            $display("vec %0d: bcd=%h run=%b alarm=%b done=%b", i, dut_bcd(), running, alarm, done);
        end

        // Asynchronous reset in the middle of a running count
        step(1, 0, 30, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("pre_reset_bcd", dut_bcd(), 16'h0029);
        chk("pre_reset_run", int'(running), 1);
        #2 reset = 1;
        #1;
        model_reset();
        chk("async_reset_bcd", dut_bcd(), 0);
        chk("async_reset_flags", dut_flags(), 0);
        $display("async reset mid-run: bcd=%h run=%b alarm=%b done=%b", dut_bcd(), running, alarm, done);
        @(negedge clk);
        reset = 0;

        // Random stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            bit ld, st, ps, tk;
            int lm, ls;
            ld = ($urandom_range(0, 99) < 6);
            lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
            ls = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 63));
            st = ($urandom_range(0, 99) < 12);
            ps = ($urandom_range(0, 99) < 5);
            tk = ($urandom_range(0, 99) < 50);
            step(ld, lm, ls, st, ps, tk);
            chk($sformatf("rnd%0d_bcd", n), dut_bcd(), model_bcd());
            chk($sformatf("rnd%0d_flags", n), dut_flags(),
                int'({m_state == 1, m_state == 3, m_done}));
            $display("rnd %0d: ld=%b st=%b ps=%b tk=%b bcd=%h run=%b alarm=%b done=%b",
                     n, ld, st, ps, tk, dut_bcd(), running, alarm, done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
